eq_arbiter: RTL and testbench

Shares one 16-bit equality comparator (`chkeq`) between two requesters, the branch-resolve unit (port 0) and the compare-and-skip unit (port 1). It arbitrates round-robin and registers the winning operands onto the comparator inputs. It captures the comparator result into a response register with valid/ready backpressure, tagged with the requester id. It sits in the execute stage, and its `cmp_*` ports wire directly to a single `chkeq` instance.

---
 rtl/eq_arbiter.sv | 115 +++++++++++
 tb/tb_eq_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_arbiter.sv
// Two-port round-robin front end for a shared 16-bit equality comparator.
// S1 registers the winning operands onto chkeq; S2 holds the tagged result under valid/ready.
module eq_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] cmp_ina,
    output logic [WIDTH-1:0] cmp_inb,
    input  logic             cmp_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_eq,
    output logic             busy
);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_id_q, s1_id_d;
    logic [WIDTH-1:0] ina_q, ina_d;
    logic [WIDTH-1:0] inb_q, inb_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_eq_q, rsp_eq_d;
    logic             last_id_q, last_id_d;

    logic             s1_en, s2_en;
    logic             gnt_vld, gnt_id, hs;

    assign s2_en = !rsp_valid_q || rsp_ready;
    assign s1_en = !s1_valid_q || s2_en;

    // Under contention the port that did not win last goes first; priority
    // only rotates on an actual handshake.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid)
            gnt_id = ~last_id_q;
        else if (req1_valid)
            gnt_id = 1'b1;
    end

    assign hs         = gnt_vld & s1_en;
    assign req0_ready = s1_en & gnt_vld & ~gnt_id;
    assign req1_ready = s1_en & gnt_vld &  gnt_id;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        ina_d       = ina_q;
        inb_d       = inb_q;
        last_id_d   = last_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_eq_d    = rsp_eq_q;

        if (s1_en) begin
            s1_valid_d = hs;
            if (hs) begin
                s1_id_d   = gnt_id;
                last_id_d = gnt_id;
                ina_d     = gnt_id ? req1_a : req0_a;
                inb_d     = gnt_id ? req1_b : req0_b;
            end
        end

        // cmp_out is only meaningful while S1 holds a live request.
        if (s2_en) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_eq_d = cmp_out;
                rsp_id_d = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= 1'b0;
            ina_q       <= '0;
            inb_q       <= '0;
            last_id_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            ina_q       <= ina_d;
            inb_q       <= inb_d;
            last_id_q   <= last_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_eq_q    <= rsp_eq_d;
        end
    end

    assign cmp_ina   = ina_q;
    assign cmp_inb   = inb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_eq    = rsp_eq_q;
    assign busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_eq_arbiter.sv
// Directed vector bench for eq_arbiter; one table row per clock cycle plus
// hand-written reset sequences.
module tb_eq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic [15:0] cmp_ina, cmp_inb;
    logic        cmp_out;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_eq, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural chkeq
    assign cmp_out = (cmp_ina == cmp_inb);

    eq_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .cmp_ina    (cmp_ina),
        .cmp_inb    (cmp_inb),
        .cmp_out    (cmp_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_eq     (rsp_eq),
        .busy       (busy)
    );

    // exp = {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, busy}
    typedef struct {
        logic        v0;
        logic [15:0] a0, b0;
        logic        v1;
        logic [15:0] a1, b1;
        logic        rr;
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                                input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                                input logic rr, input logic [5:0] exp);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1;
        v.rr = rr; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic rr, input logic [5:0] exp);
        add(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, rr, exp);
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %04h want %04h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                         input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
    endtask

    initial begin
        // single request, eq
        idle(1'b1, 6'b000000);
        add(1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0, 16'h0, 1'b1, 6'b100000);
        idle(1'b1, 6'b000001);
        idle(1'b1, 6'b001011);
        idle(1'b1, 6'b000000);
        // mismatch on port 1
        add(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFF, 16'h7FFF, 1'b1, 6'b010000);
        idle(1'b1, 6'b000001);
        idle(1'b1, 6'b001101);
        idle(1'b1, 6'b000000);
        // contention: port0 equal operands, port1 unequal
        add(1'b1, 16'h5, 16'h5, 1'b1, 16'h1, 16'h2, 1'b1, 6'b100000);
        add(1'b1, 16'h5, 16'h5, 1'b1, 16'h1, 16'h2, 1'b1, 6'b010001);
        add(1'b1, 16'h5, 16'h5, 1'b1, 16'h1, 16'h2, 1'b1, 6'b101011);
        add(1'b1, 16'h5, 16'h5, 1'b1, 16'h1, 16'h2, 1'b1, 6'b011101);
        add(1'b1, 16'h5, 16'h5, 1'b1, 16'h1, 16'h2, 1'b1, 6'b101011);
        add(1'b1, 16'h5, 16'h5, 1'b1, 16'h1, 16'h2, 1'b1, 6'b011101);
        idle(1'b1, 6'b001011);
        idle(1'b1, 6'b001101);
        idle(1'b1, 6'b000000);
        // backpressure: eq, neq, eq from port 0 while rsp_ready low
        add(1'b1, 16'h11, 16'h11, 1'b0, 16'h0, 16'h0, 1'b0, 6'b100000);
        add(1'b1, 16'h22, 16'h23, 1'b0, 16'h0, 16'h0, 1'b0, 6'b100001);
        add(1'b1, 16'h33, 16'h33, 1'b0, 16'h0, 16'h0, 1'b0, 6'b001011);
        add(1'b1, 16'h33, 16'h33, 1'b0, 16'h0, 16'h0, 1'b0, 6'b001011);
        add(1'b1, 16'h33, 16'h33, 1'b0, 16'h0, 16'h0, 1'b1, 6'b101011);
        idle(1'b1, 6'b001001);
        idle(1'b1, 6'b001011);
        idle(1'b1, 6'b000000);
        // priority hold: port1 alone, 3 idle, then two contentions
        add(1'b0, 16'h0, 16'h0, 1'b1, 16'h7, 16'h7, 1'b1, 6'b010000);
        idle(1'b1, 6'b000001);
        idle(1'b1, 6'b001111);
        idle(1'b1, 6'b000000);
        add(1'b1, 16'h40, 16'h40, 1'b1, 16'h41, 16'h42, 1'b1, 6'b100000);
        add(1'b1, 16'h50, 16'h51, 1'b1, 16'h41, 16'h42, 1'b1, 6'b010001);
        idle(1'b1, 6'b001011);
        idle(1'b1, 6'b001101);
        idle(1'b1, 6'b000000);

        // reset state, with req0 valid to show ready is combinational
        rst = 1'b1;
        drive(1'b1, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk1("rst rsp_valid", rsp_valid, 1'b0);
        chk1("rst rsp_id", rsp_id, 1'b0);
        chk1("rst rsp_eq", rsp_eq, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk16("rst cmp_ina", cmp_ina, 16'h0);
        chk16("rst cmp_inb", cmp_inb, 16'h0);
        chk1("rst req0_ready", req0_ready, 1'b1);
        chk1("rst req1_ready", req1_ready, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
            #1;
            chk1($sformatf("v%0d req0_ready", i), req0_ready, vecs[i].exp[5]);
            chk1($sformatf("v%0d req1_ready", i), req1_ready, vecs[i].exp[4]);
            chk1($sformatf("v%0d rsp_valid", i), rsp_valid, vecs[i].exp[3]);
            if (vecs[i].exp[3]) begin
                chk1($sformatf("v%0d rsp_id", i), rsp_id, vecs[i].exp[2]);
                chk1($sformatf("v%0d rsp_eq", i), rsp_eq, vecs[i].exp[1]);
            end
            chk1($sformatf("v%0d busy", i), busy, vecs[i].exp[0]);
        end

        // reset mid-operation: two back-to-back handshakes, then async reset
        @(negedge clk);
        drive(1'b1, 16'hABCD, 16'hABCD, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 chk1("mid hs1 ready", req0_ready, 1'b1);
        @(negedge clk);
        drive(1'b1, 16'h1111, 16'h2222, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 chk1("mid hs2 ready", req0_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1;
        chk1("mid pre rsp_valid", rsp_valid, 1'b1);
        chk1("mid pre busy", busy, 1'b1);
        chk16("mid pre cmp_ina", cmp_ina, 16'h1111);
        chk16("mid pre cmp_inb", cmp_inb, 16'h2222);
        rst = 1'b1;
        #1;
        chk1("mid rst rsp_valid", rsp_valid, 1'b0);
        chk1("mid rst busy", busy, 1'b0);
        chk16("mid rst cmp_ina", cmp_ina, 16'h0);
        chk16("mid rst cmp_inb", cmp_inb, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("post rst %0d rsp_valid", k), rsp_valid, 1'b0);
            chk1($sformatf("post rst %0d busy", k), busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
